// File: rtl/pu_vec.sv
// Vector MAC unit: one activation broadcast to NUM_LANES signed-weight lanes,
// accumulated over VEC_LEN beats, with optional ReLU and a result handshake.
module pu_vec #(
    parameter int NUM_LANES = 10,
    parameter int DIN_W     = 8,
    parameter int W_W       = 8,
    parameter int ACC_W     = 32,
    parameter int VEC_LEN   = 784,
    parameter int CNT_W     = $clog2(VEC_LEN + 1)
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       start_i,
    input  logic                       relu_i,
    input  logic                       mac_clear_i,
    input  logic                       en_i,
    input  logic                       valid_i,
    output logic                       in_ready_o,
    input  logic [DIN_W-1:0]           din_i,
    input  logic [NUM_LANES*W_W-1:0]   win_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       busy_o,
    output logic [NUM_LANES*ACC_W-1:0] matmul_o
);
    localparam int PW = DIN_W + W_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_OUT
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    pvalid_q, pvalid_d;
    logic                    relu_q, relu_d;
    logic signed [PW-1:0]    prod_q [NUM_LANES];
    logic signed [ACC_W-1:0] acc_q  [NUM_LANES];
    logic signed [ACC_W-1:0] acc_d  [NUM_LANES];

    logic accept;
    logic last;
    logic do_start;

    assign accept   = valid_i & en_i & (state_q == S_RUN);
    assign last     = (cnt_q == CNT_W'(VEC_LEN - 1));
    assign do_start = (state_q == S_IDLE) & start_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort dominates everything
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (accept && last) state_d = S_FLUSH;
            S_FLUSH: state_d = S_OUT;
            S_OUT:   if (out_ready_i) state_d = S_IDLE;
        endcase
        if (mac_clear_i) state_d = S_IDLE;
    end

    // Output decode of registered state
    always_comb begin
        in_ready_o  = (state_q == S_RUN);
        out_valid_o = (state_q == S_OUT);
        busy_o      = (state_q != S_IDLE);
    end

    // Stage 1: products are captured only for accepted beats
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_LANES; k++) begin
            if (accept) begin
                prod_q[k] <= $signed(din_i) * $signed(win_i[k*W_W +: W_W]);
            end
        end
    end

    // Stage 2 and control datapath
    always_comb begin
        cnt_d    = cnt_q;
        pvalid_d = accept;
        relu_d   = relu_q;
        for (int k = 0; k < NUM_LANES; k++) begin
            acc_d[k] = acc_q[k];
            if (pvalid_q) acc_d[k] = acc_q[k] + ACC_W'(prod_q[k]);
        end
        if (accept && !last) cnt_d = cnt_q + 1'b1;
        if (do_start || mac_clear_i) begin
            cnt_d    = '0;
            pvalid_d = 1'b0;
            relu_d   = mac_clear_i ? 1'b0 : relu_i;
            for (int k = 0; k < NUM_LANES; k++) acc_d[k] = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q    <= '0;
            pvalid_q <= 1'b0;
            relu_q   <= 1'b0;
            for (int k = 0; k < NUM_LANES; k++) acc_q[k] <= '0;
        end else begin
            cnt_q    <= cnt_d;
            pvalid_q <= pvalid_d;
            relu_q   <= relu_d;
            for (int k = 0; k < NUM_LANES; k++) acc_q[k] <= acc_d[k];
        end
    end

    always_comb begin
        matmul_o = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            matmul_o[k*ACC_W +: ACC_W] =
                (relu_q && acc_q[k][ACC_W-1]) ? '0 : acc_q[k];
        end
    end
endmodule
